// File: rtl/sram_pkg.sv
// Shared constants, FSM state types and geometry helpers for the AXI-lite SRAM slave.
package sram_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_WIDTH storage: byte-masked write port, registered read port, read-first on collision.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  localparam int IDX_W     = idx_w_of(DEPTH),
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BYTES-1:0]      wmask_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // NBA semantics give read-first behaviour when read and write hit the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite SRAM slave: independent write (AW/W/B) and read (AR/R) FSMs over sram_array.
// Optional SRAM_ERR_RESP_EN: out-of-range addresses return SLVERR and suppress the access.
module axi_lite_sram_slave
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp
);
  localparam int LSB   = lsb_of(DATA_WIDTH);
  localparam int IDX_W = idx_w_of(DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;

  wstate_e               w_state_q, w_state_d;
  rstate_e               r_state_q, r_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wmask_q, wmask_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit, aw_err, ar_err;
  logic [ADDR_WIDTH-1:0] waddr_eff;
  logic [DATA_WIDTH-1:0] wdata_eff, arr_rdata;
  logic [BYTES-1:0]      wmask_eff;

  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (r_state_q == R_IDLE) || rready;
  assign rvalid  = (r_state_q == R_DATA);
  assign rresp   = rresp_q;
  assign rdata   = (rresp_q == RESP_SLVERR) ? '0 : arr_rdata;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A channel captured earlier takes priority over what is currently on the bus.
  assign waddr_eff = aw_held_q ? awaddr_q : awaddr;
  assign wdata_eff = w_held_q  ? wdata_q  : wdata;
  assign wmask_eff = w_held_q  ? wmask_q  : wmask;
  assign commit    = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

`ifdef SRAM_ERR_RESP_EN
  localparam logic [ADDR_WIDTH-1:0] HI_MASK = {ADDR_WIDTH{1'b1}} << (LSB + IDX_W);
  assign aw_err = |(waddr_eff & HI_MASK);
  assign ar_err = |(araddr & HI_MASK);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Byte-offset bits (and upper bits when aliasing) are intentionally not decoded.
  logic unused_addr;
  assign unused_addr = ^{waddr_eff, araddr};

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = aw_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wmask_d  = wmask;
          end
        end
      end
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (rready && !ar_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    if (ar_hs) rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write enable is qualified by rst_n so no write lands while reset is asserted.
  sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (commit && !aw_err && rst_n),
    .waddr_i (waddr_eff[LSB +: IDX_W]),
    .wdata_i (wdata_eff),
    .wmask_i (wmask_eff),
    .re_i    (ar_hs),
    .raddr_i (araddr[LSB +: IDX_W]),
    .rdata_o (arr_rdata)
  );
endmodule
